// File: rtl/cpu_pkg.sv
// Shared datapath constants: operand-B select codes and extend-mode encodings.
package cpu_pkg;

  localparam int SRCB_SEL_SRC0  = 0;
  localparam int SRCB_SEL_CONST = 1;

  typedef enum logic [1:0] {
    SRCB_MODE_PASS     = 2'b00,
    SRCB_MODE_SEXT     = 2'b01,
    SRCB_MODE_SEXT_SH2 = 2'b10,
    SRCB_MODE_ZEXT     = 2'b11
  } srcb_mode_e;

endpackage

// File: rtl/alu_srcb_stage.sv
// Generic valid/ready register slice. Defining ALU_SRCB_SKID_EN adds a skid
// register so in_ready is registered and the slice holds two beats.
module alu_srcb_stage #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q,  out_data_d;

`ifdef ALU_SRCB_SKID_EN
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q,  skid_data_d;

  always_comb begin
    in_ready     = !skid_valid_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || out_ready) begin
      // Output slot frees up: the older skid beat always goes first.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_valid;
        if (in_valid) out_data_d = in_data;
      end
    end else if (in_valid) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  always_comb begin
    in_ready    = !out_valid_q || out_ready;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (in_ready) begin
      out_valid_d = in_valid;
      if (in_valid) out_data_d = in_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/alu_operand_b_pipe.sv
// Registered ALU operand-B selector: source decode, sign/zero extend, valid/ready
// output stage and illegal-select counter. ALU_SRCB_SKID_EN selects the skid stage.
module alu_operand_b_pipe
  import cpu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_SRC   = 3,
  parameter int IMM_W     = 16,
  parameter int CONST_VAL = 4,
  localparam int SEL_W    = $clog2(NUM_SRC + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic [1:0]               mode,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         data_out,
  output logic                     sel_err,
  output logic [7:0]               err_count
);

  int               sel_i;
  logic [WIDTH-1:0] raw_v, ext_v, imm_sext, imm_zext;
  logic [IMM_W-1:0] imm;
  logic             sel_illegal, apply_mode;
  logic [7:0]       err_count_q, err_count_d;

  always_comb begin
    sel_i       = int'(sel);
    raw_v       = '0;
    sel_illegal = 1'b0;
    apply_mode  = 1'b1;
    if (sel_i == SRCB_SEL_SRC0) begin
      raw_v = src_data[WIDTH-1:0];
    end else if (sel_i == SRCB_SEL_CONST) begin
      raw_v      = WIDTH'(CONST_VAL);
      apply_mode = 1'b0;
    end else if (sel_i > NUM_SRC) begin
      sel_illegal = 1'b1;
      apply_mode  = 1'b0;
    end else begin
      // Code k (2..NUM_SRC) maps to source k-1 because code 1 is the constant.
      for (int i = 1; i < NUM_SRC; i++) begin
        if (sel_i == i + 1) raw_v = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    imm      = raw_v[IMM_W-1:0];
    imm_sext = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
    imm_zext = {{(WIDTH-IMM_W){1'b0}}, imm};
    ext_v    = raw_v;
    if (apply_mode) begin
      case (srcb_mode_e'(mode))
        SRCB_MODE_SEXT:     ext_v = imm_sext;
        SRCB_MODE_SEXT_SH2: ext_v = imm_sext << 2;
        SRCB_MODE_ZEXT:     ext_v = imm_zext;
        default:            ext_v = raw_v;
      endcase
    end
  end

  always_comb begin
    err_count_d = err_count_q;
    if (in_valid && in_ready && sel_illegal && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_count_q <= '0;
    else          err_count_q <= err_count_d;
  end

  alu_srcb_stage #(
    .W (WIDTH + 1)
  ) u_stage (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({sel_illegal, ext_v}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({sel_err, data_out})
  );

  assign err_count = err_count_q;

endmodule

// File: tb/tb_alu_operand_b_pipe.sv
// Directed bench for alu_operand_b_pipe: default instance plus a NUM_SRC=5
// instance for illegal select codes. Works with or without ALU_SRCB_SKID_EN.
module tb_alu_operand_b_pipe;

`ifdef ALU_SRCB_SKID_EN
  localparam int SKID = 1;
`else
  localparam int SKID = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  mode;

  logic        in_valid, in_ready, out_valid, out_ready, sel_err;
  logic [1:0]  sel;
  logic [31:0] s0, s1, s2, data_out;
  logic [7:0]  err_count;

  logic        in_valid5, in_ready5, out_valid5, out_ready5, sel_err5;
  logic [2:0]  sel5;
  logic [31:0] t0, t1, t2, t3, t4, data_out5;
  logic [7:0]  err_count5;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_operand_b_pipe u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .mode(mode), .src_data({s2, s1, s0}), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .sel_err(sel_err), .err_count(err_count)
  );

  alu_operand_b_pipe #(.NUM_SRC(5)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid5), .in_ready(in_ready5),
    .sel(sel5), .mode(mode), .src_data({t4, t3, t2, t1, t0}), .out_valid(out_valid5),
    .out_ready(out_ready5), .data_out(data_out5), .sel_err(sel_err5), .err_count(err_count5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] nxt, exp;
    logic        acc, drn;
    logic [31:0] obs;
    int          e5;

    reset_n = 1'b0; mode = 2'b00;
    in_valid = 1'b1; sel = 2'd1; out_ready = 1'b1;
    s0 = 32'h1234_F00F; s1 = 32'h2222_2222; s2 = 32'h0000_8001;
    in_valid5 = 1'b0; sel5 = 3'd0; out_ready5 = 1'b1;
    t0 = 32'h1000_0000; t1 = 32'hABCD_9876; t2 = 32'h3333_3333; t3 = 32'h5555_5555; t4 = 32'h4444_4444;

    // Reset held with in_valid asserted
    repeat (3) tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_sel_err", {31'd0, sel_err}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("first_beat_valid", {31'd0, out_valid}, 32'd1);
    chk("first_beat_const", data_out, 32'h0000_0004);

    // Select and mode decode
    sel = 2'd3; mode = 2'b01; tick(); chk("sel3_sext", data_out, 32'hFFFF_8001);
    mode = 2'b10; tick(); chk("sel3_sext_sh2", data_out, 32'hFFFE_0004);
    mode = 2'b11; tick(); chk("sel3_zext", data_out, 32'h0000_8001);
    sel = 2'd2; mode = 2'b00; tick(); chk("sel2_pass", data_out, 32'h2222_2222);
    sel = 2'd1; mode = 2'b01; tick(); chk("const_ignores_mode", data_out, 32'h0000_0004);
    sel = 2'd0; mode = 2'b01; tick(); chk("sel0_sext", data_out, 32'hFFFF_F00F);
    chk("legal_sel_err", {31'd0, sel_err}, 32'd0);

    // Back-pressure: three stalled cycles
    mode = 2'b00; s0 = 32'h100; tick(); chk("bp_first", data_out, 32'h100);
    out_ready = 1'b0; s0 = 32'h101; #1;
    chk("bp_in_ready_stall", {31'd0, in_ready}, SKID);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_hold_data", data_out, 32'h100);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    end
    nxt = (SKID != 0) ? 32'h102 : 32'h101;
    exp = 32'h100;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && exp <= 32'h105; cyc++) begin
      in_valid = (nxt <= 32'h105); s0 = nxt;
      #1;
      acc = in_valid && in_ready; drn = out_valid && out_ready; obs = data_out;
      @(posedge clk); #1;
      if (drn) begin
        chk("bp_order", obs, exp);
        exp++;
      end
      if (acc) nxt++;
    end
    chk("bp_all_delivered", exp, 32'h106);
    in_valid = 1'b0; tick();
    chk("bp_empty_after", {31'd0, out_valid}, 32'd0);

    // Streaming: one beat per cycle, 1-cycle latency
    in_valid = 1'b1; out_ready = 1'b1; sel = 2'd0; mode = 2'b00;
    for (int i = 0; i < 10; i++) begin
      s0 = 32'(i);
      tick();
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_data", data_out, 32'(i));
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end

    // Reset pulsed during a stall drops the held beat
    s0 = 32'h55; tick(); chk("midrst_beat", data_out, 32'h55);
    out_ready = 1'b0; in_valid = 1'b0; tick();
    chk("midrst_stalled", {31'd0, out_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_async_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_async_data", data_out, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1; out_ready = 1'b1;
    tick();
    chk("midrst_discarded", {31'd0, out_valid}, 32'd0);
    chk("default_err_count", {24'd0, err_count}, 32'd0);

    // Illegal select codes on the NUM_SRC=5 instance
    in_valid5 = 1'b1; out_ready5 = 1'b1; mode = 2'b00;
    sel5 = 3'd7; tick();
    chk("ill7_data", data_out5, 32'd0);
    chk("ill7_sel_err", {31'd0, sel_err5}, 32'd1);
    chk("ill7_count", {24'd0, err_count5}, 32'd1);
    sel5 = 3'd5; tick();
    chk("sel5_src4", data_out5, 32'h4444_4444);
    chk("sel5_sel_err", {31'd0, sel_err5}, 32'd0);
    sel5 = 3'd2; mode = 2'b11; tick();
    chk("sel2_src1_zext", data_out5, 32'h0000_9876);
    sel5 = 3'd6; mode = 2'b00; tick();
    chk("ill6_data", data_out5, 32'd0);
    chk("ill6_count", {24'd0, err_count5}, 32'd2);
    out_ready5 = 1'b0; sel5 = 3'd7;
    repeat (3) tick();
    e5 = 2 + SKID;
    chk("stall_no_count", {24'd0, err_count5}, 32'(e5));
    chk("stall_hold_err", {31'd0, sel_err5}, 32'd1);
    out_ready5 = 1'b1;
    repeat (300) tick();
    chk("ill_saturate", {24'd0, err_count5}, 32'd255);
    repeat (5) tick();
    chk("ill_no_wrap", {24'd0, err_count5}, 32'd255);
    in_valid5 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
